// File: rtl/nano_7seg_scan.sv
// nano_7seg_scan: time-multiplexed hex 7-segment driver with tear-free loads, leading-zero blanking and dead time
module nano_7seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 27000,
    parameter int DEAD_CYCLES    = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic SAL = SEG_ACTIVE_LOW != 0;
    localparam logic DAL = DIG_ACTIVE_LOW != 0;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] LUT [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   ddp_q, ddp_d, pdp_q, pdp_d;
    logic                    pv_q, pv_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    bnd, on, lit, z;
    logic [3:0]              digit;
    logic [NUM_DIGITS-1:0]   blank;

    // Scan counters plus pending/display double buffer; display only changes at slot boundaries
    always_comb begin
        bnd    = cnt_q == LAST;
        cnt_d  = bnd ? '0 : cnt_q + 1'b1;
        idx_d  = bnd ? (idx_q == IMAX ? '0 : idx_q + 1'b1) : idx_q;
        pend_d = load ? value : pend_q;
        pdp_d  = load ? dp_in : pdp_q;
        pv_d   = bnd ? 1'b0 : (load | pv_q);
        disp_d = bnd && load ? value : (bnd && pv_q ? pend_q : disp_q);
        ddp_d  = bnd && load ? dp_in : (bnd && pv_q ? pdp_q : ddp_q);
    end

    // Leading-zero mask: digit i>0 blanks when it and every higher digit are zero
    always_comb begin
        z     = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z        = z & (disp_q[4*i +: 4] == 4'h0);
            blank[i] = z;
        end
    end

    // Next output levels, built active-high then flipped to the configured polarity
    always_comb begin
        digit = 4'(disp_q >> {idx_q, 2'b00});
        on    = enable && cnt_q >= DEAD;
        lit   = on && !(lz_blank && blank[idx_q]);
        seg_d = (lit ? ~LUT[digit] : 7'h00) ^ {7{SAL}};
        dp_d  = (on && ddp_q[idx_q]) ^ SAL;
        dig_d = (on ? NUM_DIGITS'(1) << idx_q : '0) ^ {NUM_DIGITS{DAL}};
    end

    // State and registered outputs; reset forces every output to its off level
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            ddp_q  <= '0;
            pend_q <= '0;
            pdp_q  <= '0;
            pv_q   <= 1'b0;
            seg_q  <= {7{SAL}};
            dp_q   <= SAL;
            dig_q  <= {NUM_DIGITS{DAL}};
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            ddp_q  <= ddp_d;
            pend_q <= pend_d;
            pdp_q  <= pdp_d;
            pv_q   <= pv_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            dig_q  <= dig_d;
        end
    end

    assign seg    = seg_q;
    assign dp     = dp_q;
    assign dig_en = dig_q;
endmodule

// File: tb/tb_nano_7seg_scan.sv
// tb_nano_7seg_scan: directed scan, load-timing, blanking, enable and reset checks
module tb_nano_7seg_scan;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, lz_blank = 1'b0, enable = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_en;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    nano_7seg_scan #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .lz_blank(lz_blank), .enable(enable), .seg(seg), .dp(dp), .dig_en(dig_en)
    );

    task automatic step();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [6:0] es, input logic [3:0] ed, input logic edp);
        total++;
        assert (seg === es) else begin bad++; $error("FAIL %s seg got=%h exp=%h", tag, seg, es); end
        total++;
        assert (dig_en === ed) else begin bad++; $error("FAIL %s dig_en got=%b exp=%b", tag, dig_en, ed); end
        total++;
        assert (dp === edp) else begin bad++; $error("FAIL %s dp got=%b exp=%b", tag, dp, edp); end
    endtask

    task automatic off(input string tag);
        chk(tag, 7'h7F, 4'b0000, 1'b1);
    endtask

    task automatic slot(input string tag, input logic [6:0] es, input logic [3:0] ed, input logic edp);
        step();
        off({tag, "_dead"});
        repeat (3) begin
            step();
            chk(tag, es, ed, edp);
        end
    endtask

    initial begin
        step();
        off("reset");
        rst = 1'b0;
        value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        step();
        off("first_dead");
        repeat (3) begin step(); chk("idx0_old", 7'h01, 4'b0001, 1'b1); end
        slot("idx1", 7'h06, 4'b0010, 1'b1);
        slot("idx2", 7'h12, 4'b0100, 1'b0);
        slot("idx3", 7'h4F, 4'b1000, 1'b1);
        slot("wrap_idx0", 7'h4C, 4'b0001, 1'b1);

        value = 16'h0070; dp_in = 4'b0000; lz_blank = 1'b1; load = 1'b1;
        slot("lz_old_idx1", 7'h06, 4'b0010, 1'b1);
        slot("lz_idx2", 7'h7F, 4'b0100, 1'b1);
        slot("lz_idx3", 7'h7F, 4'b1000, 1'b1);
        slot("lz_idx0", 7'h01, 4'b0001, 1'b1);
        slot("lz_idx1", 7'h0F, 4'b0010, 1'b1);
        lz_blank = 1'b0;
        slot("nolz_idx2", 7'h01, 4'b0100, 1'b1);
        slot("nolz_idx3", 7'h01, 4'b1000, 1'b1);

        step();
        off("mid_dead");
        value = 16'hAAAA; load = 1'b1;
        repeat (3) begin step(); chk("mid_keep", 7'h01, 4'b0001, 1'b1); end
        slot("mid_next", 7'h08, 4'b0010, 1'b1);
        step();
        off("bnd_dead");
        repeat (2) begin step(); chk("bnd_pre", 7'h08, 4'b0100, 1'b1); end
        value = 16'h5555; load = 1'b1;
        step();
        chk("bnd_keep", 7'h08, 4'b0100, 1'b1);
        slot("bnd_next", 7'h24, 4'b1000, 1'b1);

        value = 16'h1111; load = 1'b1;
        step();
        off("b2b_dead");
        value = 16'h6666; load = 1'b1;
        repeat (3) begin step(); chk("b2b_cur", 7'h24, 4'b0001, 1'b1); end
        slot("b2b_last", 7'h20, 4'b0010, 1'b1);

        step();
        off("en_dead");
        step();
        chk("en_pre", 7'h20, 4'b0100, 1'b1);
        enable = 1'b0;
        repeat (5) begin step(); off("en_off"); end
        enable = 1'b1;
        step();
        chk("en_resume", 7'h20, 4'b1000, 1'b1);
        slot("en_idx0", 7'h20, 4'b0001, 1'b1);

        slot("pre_rst", 7'h20, 4'b0010, 1'b1);
        step();
        off("rst_slot_dead");
        step();
        chk("rst_slot_lit", 7'h20, 4'b0100, 1'b1);
        rst = 1'b1;
        step();
        off("rst_abort");
        rst = 1'b0;
        step();
        off("post_rst_dead");
        step();
        chk("post_rst", 7'h01, 4'b0001, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
